oam_dma_ctrl: RTL and testbench

Sprite DMA sequencer for the CPU-side address space. Detects a CPU write to `$4014`, stalls the T65 through `dma_hijack`, and drives 256 read/write pairs that copy CPU page `$XX00-$XXFF` into PPU OAM. It sits between the CPU bus and the `databus` mux: `dma_hijack` and `dma_addr` feed the mux's DMA inputs and gate CPU `Enable`; OAM write strobes go to the PPU sprite RAM.

---
 rtl/oam_dma_ctrl_if.sv | 26 ++
 rtl/oam_dma_ctrl.sv | 145 ++++++++++++++
 tb/tb_oam_dma_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_ctrl_if.sv
// Bus bundle for the sprite DMA sequencer: CPU-side trigger inputs, bus-mux
// DMA read path and the PPU OAM write port.
interface oam_dma_ctrl_if;
  logic [15:0] bus_addr;
  logic        bus_rw_n;
  logic [7:0]  bus_din;
  logic [7:0]  dma_rdata;
  logic [7:0]  oam_base;
  logic        dma_hijack;
  logic [15:0] dma_addr;
  logic        oam_we;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        dma_done;

  // The DMA controller owns the bus while hijacking.
  modport master (
    input  bus_addr, bus_rw_n, bus_din, dma_rdata, oam_base,
    output dma_hijack, dma_addr, oam_we, oam_addr, oam_wdata, dma_done
  );

  modport slave (
    output bus_addr, bus_rw_n, bus_din, dma_rdata, oam_base,
    input  dma_hijack, dma_addr, oam_we, oam_addr, oam_wdata, dma_done
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA sequencer: a CPU write to TRIGGER_ADDR stalls the CPU and copies one
// page into PPU OAM. Define OAM_DMA_ALIGN_EN for the parity-driven ALIGN cycle.
module oam_dma_ctrl #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter int          XFER_LEN     = 256
) (
  input  logic           cpu_clk,
  input  logic           reset,
  oam_dma_ctrl_if.master bus
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

`ifdef OAM_DMA_ALIGN_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;
`endif

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_page;
  logic [7:0]  r_idx;
  logic [7:0]  w_idx_next;
  logic [7:0]  r_data_q;
  logic [15:0] r_dma_addr;
  logic        r_hijack;
  logic        r_done;
  logic        w_trigger;
  logic        w_last;
  logic        w_load_page;
  logic        w_in_write;

  assign w_trigger   = (bus.bus_addr == TRIGGER_ADDR) && !bus.bus_rw_n;
  assign w_last      = (r_idx == LAST_IDX);
  assign w_in_write  = (r_state == ST_WRITE);
  assign w_load_page = (r_state == ST_IDLE) && w_trigger;

`ifdef OAM_DMA_ALIGN_EN
  logic r_parity;

  // Free-running CPU cycle parity.
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= ~r_parity;
    end
  end
`endif

  // Next-state and transfer index.
  always_comb begin
    w_next_state = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_trigger) begin
          w_next_state = ST_HALT;
          w_idx_next   = 8'd0;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        if (r_parity) begin
          w_next_state = ST_ALIGN;
        end else begin
          w_next_state = ST_READ;
        end
`else
        w_next_state = ST_READ;
`endif
      end
`ifdef OAM_DMA_ALIGN_EN
      ST_ALIGN: w_next_state = ST_READ;
`endif
      ST_READ:  w_next_state = ST_WRITE;
      ST_WRITE: begin
        if (w_last) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_READ;
          w_idx_next   = r_idx + 8'd1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_idx_next   = 8'd0;
      end
    endcase
  end

  // Sequencer state, latched page/data and registered bus outputs.
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_page     <= 8'h00;
      r_idx      <= 8'h00;
      r_data_q   <= 8'h00;
      r_dma_addr <= 16'h0000;
      r_hijack   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_idx    <= w_idx_next;
      r_hijack <= (w_next_state != ST_IDLE);
      r_done   <= w_in_write && w_last;
      if (w_load_page) begin
        r_page <= bus.bus_din;
      end
      if (r_state == ST_READ) begin
        r_data_q <= bus.dma_rdata;
      end
      // Address is set up at the edge entering READ and held through WRITE.
      if (w_next_state == ST_READ) begin
        r_dma_addr <= {r_page, w_idx_next};
      end else if (w_next_state == ST_WRITE) begin
        r_dma_addr <= r_dma_addr;
      end else begin
        r_dma_addr <= 16'h0000;
      end
    end
  end

  assign bus.dma_hijack = r_hijack;
  assign bus.dma_addr   = r_dma_addr;
  assign bus.dma_done   = r_done;
  assign bus.oam_we     = w_in_write;
  assign bus.oam_addr   = w_in_write ? (bus.oam_base + r_idx) : 8'h00;
  assign bus.oam_wdata  = w_in_write ? r_data_q : 8'h00;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: expected OAM writes are queued at trigger
// time and popped as the DUT strobes oam_we.
module tb_oam_dma_ctrl;

`ifdef OAM_DMA_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic cpu_clk = 1'b0;
  logic reset   = 1'b1;

  oam_dma_ctrl_if bus ();

  oam_dma_ctrl #(
    .TRIGGER_ADDR(16'h4014),
    .XFER_LEN    (256)
  ) dut (
    .cpu_clk(cpu_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 cpu_clk = ~cpu_clk;

  logic [7:0] mem [0:65535];
  assign bus.dma_rdata = mem[bus.dma_addr];

  // Reference model of the CPU cycle parity (reset 0, toggles every edge).
  bit tb_par;
  always @(posedge cpu_clk or posedge reset) begin
    if (reset) tb_par <= 1'b0;
    else       tb_par <= ~tb_par;
  end

  typedef struct packed {
    logic [15:0] src;
    logic [7:0]  oaddr;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic idle_bus();
    bus.bus_addr = 16'h0000;
    bus.bus_rw_n = 1'b1;
    bus.bus_din  = 8'h00;
  endtask

  task automatic drive_write(input logic [15:0] a, input logic [7:0] d);
    bus.bus_addr = a;
    bus.bus_rw_n = 1'b0;
    bus.bus_din  = d;
  endtask

  // Full transfer: queue expectations, trigger, then consume OAM writes.
  task automatic run_transfer(input logic [7:0] page, input logic [7:0] base,
                              input int want_par, input int glitch_at, input string tag);
    int   exp_len;
    int   hij;
    int   dones;
    bit   hp;
    bit   seen_done;
    exp_t e;
    bus.oam_base = base;
    if (want_par >= 0 && (~tb_par) != want_par[0]) @(negedge cpu_clk);
    hp      = ~tb_par;
    exp_len = 513 + ((ALIGN_EN && hp) ? 1 : 0);
    for (int i = 0; i < 256; i++) begin
      e.src   = {page, 8'(i)};
      e.oaddr = base + 8'(i);
      e.data  = mem[e.src];
      sb.push_back(e);
    end
    drive_write(16'h4014, page);
    @(negedge cpu_clk);
    idle_bus();
    hij = 0;
    dones = 0;
    seen_done = 1'b0;
    for (int cyc = 0; cyc < 700 && !seen_done; cyc++) begin
      if (glitch_at > 0 && cyc == glitch_at) drive_write(16'h4014, page ^ 8'hFF);
      else if (glitch_at > 0 && cyc == glitch_at + 1) idle_bus();
      if (bus.dma_hijack === 1'b1) hij++;
      if (bus.oam_we === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL %s unexpected_write: got addr %h data %h required none", tag,
                   bus.oam_addr, bus.oam_wdata);
        end else begin
          e = sb.pop_front();
          if ({bus.oam_addr, bus.oam_wdata, bus.dma_addr} !== {e.oaddr, e.data, e.src}) begin
            n_err++;
            $display("FAIL %s oam_write: got oaddr %h data %h src %h required oaddr %h data %h src %h",
                     tag, bus.oam_addr, bus.oam_wdata, bus.dma_addr, e.oaddr, e.data, e.src);
          end
        end
      end
      if (bus.dma_done === 1'b1) begin
        dones++;
        seen_done = 1'b1;
        n_cmp++;
        if (bus.dma_hijack !== 1'b0) begin
          n_err++;
          $display("FAIL %s hijack_at_done: got %b required 0", tag, bus.dma_hijack);
        end
      end
      if (!seen_done) @(negedge cpu_clk);
    end
    n_cmp++;
    if (hij != exp_len) begin
      n_err++;
      $display("FAIL %s hijack_len: got %0d required %0d", tag, hij, exp_len);
    end
    n_cmp++;
    if (dones != 1) begin
      n_err++;
      $display("FAIL %s done_count: got %0d required 1", tag, dones);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s writes_missing: got %0d left required 0", tag, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge cpu_clk);
    n_cmp++;
    if ({bus.dma_hijack, bus.dma_addr, bus.oam_we, bus.oam_addr, bus.oam_wdata, bus.dma_done} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_in: got hij %b addr %h we %b oa %h od %h done %b required all 0",
               bus.dma_hijack, bus.dma_addr, bus.oam_we, bus.oam_addr, bus.oam_wdata, bus.dma_done);
    end
    reset = 1'b0;
    repeat (2) @(negedge cpu_clk);
    n_cmp++;
    if ({bus.dma_hijack, bus.dma_addr, bus.oam_we, bus.oam_addr, bus.oam_wdata, bus.dma_done} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_after: got hij %b addr %h we %b required all 0",
               bus.dma_hijack, bus.dma_addr, bus.oam_we);
    end
  endtask

  task automatic test_no_trigger();
    bus.bus_addr = 16'h4014;
    bus.bus_rw_n = 1'b1;
    bus.bus_din  = 8'h02;
    @(negedge cpu_clk);
    drive_write(16'h4015, 8'h02);
    @(negedge cpu_clk);
    idle_bus();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({bus.dma_hijack, bus.dma_addr, bus.oam_we, bus.oam_addr, bus.oam_wdata, bus.dma_done} !== 35'd0) begin
        n_err++;
        $display("FAIL no_trigger: got hij %b addr %h we %b done %b required all 0",
                 bus.dma_hijack, bus.dma_addr, bus.oam_we, bus.dma_done);
      end
      @(negedge cpu_clk);
    end
  endtask

  task automatic test_reset_mid();
    int hij;
    bus.oam_base = 8'h00;
    drive_write(16'h4014, 8'h02);
    @(negedge cpu_clk);
    idle_bus();
    hij = 0;
    for (int cyc = 0; cyc < 200 && hij < 100; cyc++) begin
      if (bus.dma_hijack === 1'b1) hij++;
      @(negedge cpu_clk);
    end
    n_cmp++;
    if (hij != 100) begin
      n_err++;
      $display("FAIL reset_mid_reach: got %0d hijack cycles required 100", hij);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.dma_hijack, bus.dma_addr, bus.oam_we, bus.oam_addr, bus.oam_wdata, bus.dma_done} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_mid_zero: got hij %b addr %h we %b done %b required all 0",
               bus.dma_hijack, bus.dma_addr, bus.oam_we, bus.dma_done);
    end
    @(negedge cpu_clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge cpu_clk);
      n_cmp++;
      if ({bus.dma_hijack, bus.dma_done} !== 2'b00) begin
        n_err++;
        $display("FAIL reset_mid_after: got hij %b done %b required 0 0", bus.dma_hijack, bus.dma_done);
      end
    end
    run_transfer(8'h02, 8'h00, -1, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_transfer(8'h05, 8'h10, -1, 0, "b2b_first");
    run_transfer(8'h06, 8'h00, -1, 0, "b2b_second");
  endtask

  initial begin : main
    logic [15:0] av;
    logic [7:0]  hi;
    for (int a = 0; a < 65536; a++) begin
      av = 16'(a);
      hi = av[15:8] ^ 8'h02;
      mem[a] = av[7:0] ^ 8'hA5 ^ (hi * 8'h1D);
    end
    idle_bus();
    bus.oam_base = 8'h00;
    test_reset();
    run_transfer(8'h02, 8'h00, 0, 0, "basic_par0");
    run_transfer(8'h02, 8'h00, 1, 37, "basic_par1");
    run_transfer(8'h03, 8'hF0, -1, 0, "oam_wrap");
    test_no_trigger();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
